// File: rtl/filter2d_out_pack.sv
// -----------------------------------------------------------------------------
// filter2d_out_pack
// Output stage of the 2D filter. Packs four consecutive 8-bit filter results
// into one 32-bit word (byte0 = earliest pixel) and writes it into a ping-pong
// output memory. Tracks per-bank ownership with the consumer, drops whole frames
// whose target bank is still owned by the consumer, and signals when a new
// filter pass may be started.
//
// Optional feature macro: FILTER2D_OUT_SUM_EN
//   defined     : per-frame 16-bit pixel checksum on frame_sum
//   not defined : frame_sum tied to zero, no accumulator
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   i_strb, i_data        pixel stream from the filter (never back-pressured)
//   wr_en/wr_addr/wr_data output memory write port, wr_addr = {bank, word}
//   frame_done/frame_bank one-cycle pulse when a bank becomes full, and its id
//   full                  per-bank consumer ownership flags
//   start_ok              filter may be started (idle and write bank free)
//   rel, rel_bank         consumer releases a bank
//   ovf, ovf_clr          sticky dropped-frame flag and its clear
//   frame_sum             checksum of the last completed frame
// -----------------------------------------------------------------------------
module filter2d_out_pack #(
   parameter  int WIDTH = 256,
   localparam int WORDS = (WIDTH * WIDTH) / 4,
   localparam int AW    = $clog2(WORDS) + 1
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          i_strb,
   input  logic [7:0]    i_data,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic [31:0]   wr_data,
   output logic          frame_done,
   output logic          frame_bank,
   output logic [1:0]    full,
   output logic          start_ok,
   input  logic          rel,
   input  logic          rel_bank,
   output logic          ovf,
   input  logic          ovf_clr,
   output logic [15:0]   frame_sum
);

   localparam int PIX = WIDTH * WIDTH;
   localparam int PW  = $clog2(PIX);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_DROP = 2'd2
   } state_t;

   state_t        state_r;
   logic          wbank_r;
   logic [PW-1:0] pcnt_r;
   logic [23:0]   pack_r;
   logic [1:0]    full_r;
   logic [1:0]    full_nxt_s;
   logic          take_s;
   logic          drop_s;
   logic          last_s;

   assign last_s   = (pcnt_r == PW'(PIX - 1));
   assign full     = full_r;
   assign start_ok = (state_r == ST_IDLE) && !full_r[wbank_r];

   // Classify the current strobe: accepted into a bank, or discarded.
   always_comb begin
      take_s = 1'b0;
      drop_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            // The entering strobe is itself the first pixel of the frame.
            if (i_strb) begin
               take_s = !full_r[wbank_r];
               drop_s = full_r[wbank_r];
            end else begin
               take_s = 1'b0;
               drop_s = 1'b0;
            end
         end
         ST_FILL: take_s = i_strb;
         ST_DROP: drop_s = i_strb;
         default: begin
            take_s = 1'b0;
            drop_s = 1'b0;
         end
      endcase
   end

   // Bank ownership: consumer release first, frame-end set last so it wins.
   always_comb begin
      full_nxt_s = full_r;
      if (rel) begin
         full_nxt_s[rel_bank] = 1'b0;
      end else begin
         full_nxt_s = full_r;
      end
      if (take_s && last_s) begin
         full_nxt_s[wbank_r] = 1'b1;
      end else begin
         full_nxt_s[wbank_r] = full_nxt_s[wbank_r];
      end
   end

   // Frame state machine with packing, write port and ownership registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r    <= ST_IDLE;
         wbank_r    <= 1'b0;
         pcnt_r     <= '0;
         pack_r     <= 24'h000000;
         full_r     <= 2'b00;
         ovf        <= 1'b0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= 32'h00000000;
         frame_done <= 1'b0;
         frame_bank <= 1'b0;
      end else begin
         wr_en      <= 1'b0;
         frame_done <= 1'b0;
         full_r     <= full_nxt_s;

         if (take_s || drop_s) begin
            pcnt_r <= last_s ? '0 : pcnt_r + PW'(1);
         end

         if (take_s) begin
            state_r <= last_s ? ST_IDLE : ST_FILL;
         end else if (drop_s) begin
            state_r <= last_s ? ST_IDLE : ST_DROP;
         end

         // Overflow is decided once, on the entering strobe; set beats clear.
         if (drop_s && (state_r == ST_IDLE)) begin
            ovf <= 1'b1;
         end else if (ovf_clr) begin
            ovf <= 1'b0;
         end

         if (take_s) begin
            case (pcnt_r[1:0])
               2'd0: pack_r[7:0]   <= i_data;
               2'd1: pack_r[15:8]  <= i_data;
               2'd2: pack_r[23:16] <= i_data;
               2'd3: begin
                  wr_en   <= 1'b1;
                  wr_data <= {i_data, pack_r};
                  wr_addr <= {wbank_r, pcnt_r[PW-1:2]};
               end
               default: pack_r <= pack_r;
            endcase
         end

         // Frame end always lands on lane 3, i.e. together with the last write.
         if (take_s && last_s) begin
            frame_done <= 1'b1;
            frame_bank <= wbank_r;
            wbank_r    <= ~wbank_r;
         end
      end
   end

`ifdef FILTER2D_OUT_SUM_EN
   logic [15:0] acc_r;
   logic [15:0] acc_nxt_s;
   logic [15:0] sum_r;

   // Restart the running sum with the first pixel of each accepted frame.
   always_comb begin
      if (state_r == ST_IDLE) begin
         acc_nxt_s = {8'h00, i_data};
      end else begin
         acc_nxt_s = acc_r + {8'h00, i_data};
      end
   end

   // Accumulate accepted pixels and publish the total on frame end.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_r <= 16'h0000;
         sum_r <= 16'h0000;
      end else if (take_s) begin
         acc_r <= acc_nxt_s;
         if (last_s) begin
            sum_r <= acc_nxt_s;
         end
      end
   end

   assign frame_sum = sum_r;
`else
   assign frame_sum = 16'h0000;
`endif

endmodule

// File: doc/filter2d_out_pack.md
# filter2d_out_pack

Downstream stage of the 2D filter operator. It takes the filter's 8-bit result strobe stream and packs four consecutive pixels into 32-bit words. It writes those words into a two-bank (ping-pong) output memory and tracks bank ownership with the consumer (DMA/bus reader). It also tells the control logic when a new filter pass may be started.

## Interface
- WIDTH, 256, image side in pixels; one frame = WIDTH*WIDTH pixels. WIDTH*WIDTH must be a multiple of 4.
- WORDS (localparam), WIDTH*WIDTH/4, number of 32-bit words per bank.
- AW (localparam), $clog2(WORDS)+1, word address width; the MSB is the bank bit.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- i_strb  in  1  pixel valid from the filter stage; one pixel per strobe, never back-pressured.
- i_data  in  8  filtered pixel.
- wr_en  out  1  output memory write strobe.
- wr_addr  out  AW  {bank, word index}.
- wr_data  out  32  packed word; byte0 [7:0] is the earliest pixel.
- frame_done  out  1  one-cycle pulse; bank frame_bank has just become full.
- frame_bank  out  1  bank completed by the last frame_done.
- full  out  2  per-bank full flags (bank owned by consumer).
- start_ok  out  1  the filter may be started: state IDLE and full[wbank]==0.
- rel  in  1  consumer release pulse.
- rel_bank  in  1  bank being released.
- ovf  out  1  sticky: a frame was dropped because its bank was full.
- ovf_clr  in  1  clears ovf.
- frame_sum  out  16  per-frame pixel checksum (see Configuration).

## Operation
- State machine states are IDLE, FILL and DROP.
  - IDLE: on i_strb, go to FILL if full[wbank]==0, else go to DROP and set ovf. The first pixel is processed in the same cycle, not lost.
  - FILL: pack pixels and write words to bank wbank. On the last pixel of the frame, go to IDLE.
  - DROP: discard pixels and perform no writes. On the last pixel of the frame, go to IDLE; wbank and full are unchanged.
- Pixel counter pcnt counts 0..WIDTH*WIDTH-1 on i_strb in FILL/DROP (and on the entering strobe in IDLE). It wraps to 0 at frame end.
- Byte lane is pcnt[1:0]. The shift/pack register takes i_data in lane pcnt[1:0].
- When lane 3 is accepted in FILL:
  - wr_en=1 next cycle;
  - wr_data = the 4 packed bytes;
  - wr_addr = {wbank, pcnt[..2]}.
- Frame end in FILL, which coincides with the final wr_en cycle:
  - frame_done=1;
  - frame_bank=wbank;
  - full[wbank] set;
  - wbank toggles.
- Release: on rel, full[rel_bank] is cleared. Releasing a bank that is not full is ignored.
- If rel of bank X and frame-end set of bank Y (X≠Y) occur in the same cycle, both apply. If X==Y, the set wins.
- ovf_clr clears ovf. If it coincides with a new overflow, the set wins.
- start_ok is combinational from state, wbank and full.

## Timing
- Reset values:
  - wr_en=0, wr_addr=0, wr_data=0;
  - frame_done=0, frame_bank=0;
  - full=2'b00, ovf=0, frame_sum=0;
  - state=IDLE, wbank=0, pcnt=0.
- start_ok=1 after reset.
- Latency: i_strb of lane 3 at edge N gives wr_en high during cycle N+1, exactly one cycle wide.
- Back-to-back strobes are supported: sustained 1 pixel/clk gives one wr_en every 4 cycles.
- Gapped strobes are also supported; packing state holds between strobes.
- frame_done, full set and wbank toggle all take effect on the same edge as the final wr_en.
- Reset asserted mid-frame aborts immediately. The partial word is discarded and no write is issued.

## Configuration
- FILTER2D_OUT_SUM_EN defined:
  - a 16-bit accumulator adds each pixel accepted in FILL (mod 2^16) and is cleared at frame start;
  - frame_sum is loaded on the frame_done edge and holds until the next frame_done.
- Not defined: frame_sum is tied to 0 and no accumulator is built.

## Test plan
- WIDTH=4 (16 pixels), continuous strobes with pixels 0x00..0x0F -> wr_en 4 times at addr 0..3 of bank 0 with words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C. frame_done pulses with the 4th write, full=01, start_ok=1.
- Second frame of 0x10..0x1F -> writes to addr {1,0..3}, full=11, start_ok=0. Then rel with rel_bank=0 -> full=10, start_ok=1.
- Third frame while full=11 -> no wr_en, ovf=1, full unchanged, state returns to IDLE after 16 strobes. ovf_clr -> ovf=0.
- Strobes with random 0–3 cycle gaps -> same words and addresses as the continuous case.
- reset_n low after 6 pixels -> all outputs return to reset values immediately. A following full frame writes bank 0 from addr 0.
- With FILTER2D_OUT_SUM_EN and pixels 0x00..0x0F -> frame_sum=0x0078 at frame_done.
